// File: rtl/cmd_proc_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the command processor.
package cmd_proc_pkg;

  typedef enum logic [3:0] {
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2,
    OP_GO    = 4'h3
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_TX_HI     = 3'd2,
    ST_TX_LAST   = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;
  localparam logic [7:0] RESP_TMO = 8'h5A;

endpackage

// File: rtl/cmd_regfile.sv
// NREGS x 16-bit control registers: one synchronous write port, one combinational
// read port and a flattened view of the whole bank.
module cmd_regfile #(
  parameter int NREGS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [3:0]            waddr,
  input  logic [15:0]           wdata,
  input  logic [3:0]            raddr,
  output logic [15:0]           rdata,
  output logic [16*NREGS-1:0]   regs_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [15:0] r_word;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_word <= '0;
        end else if (we && waddr == 4'(gi)) begin
          r_word <= wdata;
        end
      end

      assign regs_out[16*gi +: 16] = r_word;
    end
  endgenerate

  // Out-of-range read addresses return zero; the FSM never uses them anyway.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr == 4'(i)) rdata = regs_out[16*i +: 16];
    end
  end

endmodule

// File: rtl/cmd_proc.sv
// Command processor: accepts 24-bit commands, executes register writes/reads or an
// external go/done operation, and returns one or two response bytes.
module cmd_proc
  import cmd_proc_pkg::*;
#(
  parameter int NREGS       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_rdy,
  input  logic [7:0]            cmd,
  input  logic [15:0]           data,
  output logic                  clr_cmd_rdy,
  output logic                  snd_resp,
  output logic [7:0]            resp,
  input  logic                  resp_sent,
  output logic                  go,
  input  logic                  done,
  output logic [16*NREGS-1:0]   regs_out
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]        NREGS_W  = 5'(NREGS);

  state_e            r_state;
  logic [7:0]        r_cmd;
  logic [15:0]       r_data;
  logic [7:0]        r_resp;
  logic              r_snd_resp;
  logic              r_go;
  logic [CNT_W-1:0]  r_cnt;

  logic [3:0]        w_op;
  logic [3:0]        w_addr;
  logic              w_addr_ok;
  logic              w_we;
  logic [15:0]       w_rdata;

  assign w_op      = r_cmd[7:4];
  assign w_addr    = r_cmd[3:0];
  assign w_addr_ok = {1'b0, w_addr} < NREGS_W;
  assign w_we      = (r_state == ST_EXEC) && (w_op == OP_WRITE) && w_addr_ok;

  assign clr_cmd_rdy = (r_state == ST_IDLE) && cmd_rdy;
  assign snd_resp    = r_snd_resp;
  assign resp        = r_resp;
  assign go          = r_go;

  cmd_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (w_we),
    .waddr    (w_addr),
    .wdata    (r_data),
    .raddr    (w_addr),
    .rdata    (w_rdata),
    .regs_out (regs_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_data     <= '0;
      r_resp     <= '0;
      r_snd_resp <= 1'b0;
      r_go       <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_snd_resp <= 1'b0;
      r_go       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_rdy) begin
            r_cmd   <= cmd;
            r_data  <= data;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_op == OP_WRITE && w_addr_ok) begin
            r_resp     <= RESP_ACK;
            r_snd_resp <= 1'b1;
            r_state    <= ST_TX_LAST;
          end else if (w_op == OP_READ && w_addr_ok) begin
            r_resp     <= w_rdata[15:8];
            r_snd_resp <= 1'b1;
            r_state    <= ST_TX_HI;
          end else if (w_op == OP_GO) begin
            r_go    <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_WAIT_DONE;
          end else begin
            r_resp     <= RESP_NAK;
            r_snd_resp <= 1'b1;
            r_state    <= ST_TX_LAST;
          end
        end
        ST_TX_HI: begin
          if (resp_sent) begin
            r_resp     <= w_rdata[7:0];
            r_snd_resp <= 1'b1;
            r_state    <= ST_TX_LAST;
          end
        end
        ST_TX_LAST: begin
          if (resp_sent) r_state <= ST_IDLE;
        end
        ST_WAIT_DONE: begin
          // Saturate rather than wrap so a stuck operation cannot alias back to zero.
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (done) begin
            r_resp     <= RESP_ACK;
            r_snd_resp <= 1'b1;
            r_state    <= ST_TX_LAST;
          end else if (r_cnt == CNT_LAST) begin
            r_resp     <= RESP_TMO;
            r_snd_resp <= 1'b1;
            r_state    <= ST_TX_LAST;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc: writes, two-byte reads, go/done, timeout, illegal
// commands, busy/stray inputs and reset during a pending operation.
module tb_cmd_proc;

  localparam int NREGS = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cmd_rdy;
  logic [7:0]          cmd;
  logic [15:0]         data;
  logic                clr_cmd_rdy;
  logic                snd_resp;
  logic [7:0]          resp;
  logic                resp_sent;
  logic                go;
  logic                done;
  logic [16*NREGS-1:0] regs_out;

  int checks   = 0;
  int failures = 0;

  cmd_proc #(.NREGS(NREGS), .TIMEOUT_CYC(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .snd_resp    (snd_resp),
    .resp        (resp),
    .resp_sent   (resp_sent),
    .go          (go),
    .done        (done),
    .regs_out    (regs_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command in the current (IDLE) cycle; returns in the EXEC cycle.
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d, input string tag);
    cmd_rdy = 1'b1;
    cmd     = c;
    data    = d;
    #1;
    check({tag, "_clr"}, 128'(clr_cmd_rdy), 128'(1));
    tick();
    cmd_rdy = 1'b0;
  endtask

  // Pulse resp_sent for one cycle; returns in the cycle after the pulse.
  task automatic ack();
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
  endtask

  // From the EXEC cycle: the response must appear exactly one cycle later.
  task automatic expect_resp_next(input logic [7:0] exp, input string tag);
    tick();
    check({tag, "_snd"}, 128'(snd_resp), 128'(1));
    check({tag, "_resp"}, 128'(resp), 128'(exp));
  endtask

  logic [16*NREGS-1:0] saved_regs;
  int                  n_go;
  int                  n_snd;
  int                  n_clr;
  int                  cyc;

  initial begin
    rst_n = 1'b0; cmd_rdy = 1'b0; cmd = '0; data = '0; resp_sent = 1'b0; done = 1'b0;
    tick();
    tick();
    check("rst_regs", 128'(regs_out), 128'(0));
    check("rst_snd", 128'(snd_resp), 128'(0));
    check("rst_go", 128'(go), 128'(0));
    check("rst_resp", 128'(resp), 128'(0));
    rst_n = 1'b1;
    tick();

    // WRITE reg3 = 0xBEEF
    send_cmd(8'h13, 16'hBEEF, "wr3");
    check("wr3_exec_snd", 128'(snd_resp), 128'(0));
    expect_resp_next(8'hA5, "wr3");
    check("wr3_reg", 128'(regs_out[63:48]), 128'(16'hBEEF));
    tick();
    check("wr3_snd_once", 128'(snd_resp), 128'(0));
    ack();

    // READ reg3: two bytes, high first, no third pulse
    send_cmd(8'h23, 16'h0000, "rd3");
    expect_resp_next(8'hBE, "rd3_hi");
    tick();
    ack();
    check("rd3_lo_snd", 128'(snd_resp), 128'(1));
    check("rd3_lo_resp", 128'(resp), 128'(8'hEF));
    tick();
    ack();
    n_snd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (snd_resp) n_snd++;
    end
    check("rd3_no_third", 128'(n_snd), 128'(0));

    // GO with done 50 cycles after go
    send_cmd(8'h30, 16'h0000, "go");
    check("go_exec_go", 128'(go), 128'(0));
    tick();
    check("go_pulse", 128'(go), 128'(1));
    n_go = 1; n_snd = 0;
    for (int i = 1; i < 50; i++) begin
      tick();
      if (go) n_go++;
      if (snd_resp) n_snd++;
    end
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("go_count", 128'(n_go), 128'(1));
    check("go_early_snd", 128'(n_snd), 128'(0));
    check("go_done_snd", 128'(snd_resp), 128'(1));
    check("go_done_resp", 128'(resp), 128'(8'hA5));
    tick();
    ack();

    // GO with no done: timeout after 100 cycles
    send_cmd(8'h30, 16'h0000, "tmo");
    tick();
    check("tmo_go", 128'(go), 128'(1));
    cyc = 0;
    while (!snd_resp && cyc < 300) begin
      tick();
      cyc++;
    end
    check("tmo_latency", 128'(cyc), 128'(100));
    check("tmo_resp", 128'(resp), 128'(8'h5A));
    tick();
    ack();

    // Illegal opcode and out-of-range address
    saved_regs = regs_out;
    send_cmd(8'h70, 16'h1234, "badop");
    expect_resp_next(8'hEE, "badop");
    tick();
    ack();
    check("badop_regs", 128'(regs_out), 128'(saved_regs));
    send_cmd(8'h1A, 16'h5555, "badaddr");
    expect_resp_next(8'hEE, "badaddr");
    tick();
    ack();
    check("badaddr_regs", 128'(regs_out), 128'(saved_regs));

    // Busy: cmd_rdy held through TX_LAST, accepted only after resp_sent
    send_cmd(8'h15, 16'h1122, "wr5");
    cmd_rdy = 1'b1; cmd = 8'h25; data = 16'h0000;
    #1;
    check("busy_exec_clr", 128'(clr_cmd_rdy), 128'(0));
    tick();
    check("wr5_snd", 128'(snd_resp), 128'(1));
    check("wr5_resp", 128'(resp), 128'(8'hA5));
    n_clr = 0;
    for (int i = 0; i < 4; i++) begin
      if (clr_cmd_rdy) n_clr++;
      tick();
    end
    resp_sent = 1'b1;
    #1;
    if (clr_cmd_rdy) n_clr++;
    check("busy_no_clr", 128'(n_clr), 128'(0));
    tick();
    resp_sent = 1'b0;
    #1;
    check("busy_accept_clr", 128'(clr_cmd_rdy), 128'(1));
    tick();
    cmd_rdy = 1'b0;
    expect_resp_next(8'h11, "rd5_hi");
    tick();
    ack();
    check("rd5_lo_resp", 128'(resp), 128'(8'h22));
    tick();
    ack();

    // Stray done/resp_sent in IDLE
    saved_regs = regs_out;
    done = 1'b1; resp_sent = 1'b1;
    tick();
    done = 1'b0; resp_sent = 1'b0;
    n_snd = 0; n_go = 0; n_clr = 0;
    for (int i = 0; i < 5; i++) begin
      if (snd_resp) n_snd++;
      if (go) n_go++;
      if (clr_cmd_rdy) n_clr++;
      tick();
    end
    check("stray_snd", 128'(n_snd), 128'(0));
    check("stray_go", 128'(n_go), 128'(0));
    check("stray_clr", 128'(n_clr), 128'(0));
    check("stray_regs", 128'(regs_out), 128'(saved_regs));

    // Reset while in WAIT_DONE aborts without a response
    send_cmd(8'h30, 16'h0000, "rstgo");
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstgo_regs", 128'(regs_out), 128'(0));
    check("rstgo_go", 128'(go), 128'(0));
    done = 1'b1;
    n_snd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (snd_resp) n_snd++;
    end
    done = 1'b0;
    check("rstgo_no_snd", 128'(n_snd), 128'(0));
    send_cmd(8'h23, 16'h0000, "rd3_post_rst");
    expect_resp_next(8'h00, "rd3_post_rst");
    tick();
    ack();
    check("rd3_post_rst_lo", 128'(resp), 128'(8'h00));
    tick();
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
